// File: rtl/sig_chan_fifo.sv
// Multi-channel FIFO bridge: NCH independent first-word-fall-through queues of
// packed [LANES][W] words, each with its own handshake, occupancy, flush and
// drop accounting. BLOCKING selects backpressure or drop-on-full behaviour.
module sig_chan_fifo #(
    parameter int unsigned NCH      = 3,
    parameter int unsigned LANES    = 3,
    parameter int unsigned W        = 8,
    parameter int unsigned DEPTH    = 4,
    parameter bit          BLOCKING = 1'b1,
    localparam int unsigned LW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH-1:0]            in_valid,
    output logic [NCH-1:0]            in_ready,
    input  logic [LANES-1:0][W-1:0]   in_data   [NCH],
    output logic [NCH-1:0]            out_valid,
    input  logic [NCH-1:0]            out_ready,
    output logic [LANES-1:0][W-1:0]   out_data  [NCH],
    input  logic [NCH-1:0]            flush,
    output logic [LW-1:0]             level     [NCH],
    output logic [15:0]               drop_cnt  [NCH],
    output logic [NCH-1:0]            drop_seen
);

    localparam int unsigned PW = $clog2(DEPTH);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [LANES-1:0][W-1:0] mem [DEPTH];
        logic [PW-1:0]           rd_ptr;
        logic [PW-1:0]           wr_ptr;
        logic [LW-1:0]           lvl;
        logic [15:0]             dcnt;
        logic                    dseen;
        logic                    full;
        logic                    empty;
        logic                    push;
        logic                    pop;
        logic                    drop;

        // Status and handshake decode from registered occupancy only.
        always_comb begin
            full  = (lvl == LW'(DEPTH));
            empty = (lvl == '0);
            // A full channel never accepts, even if it pops this cycle.
            push  = in_valid[c] & in_ready[c] & ~full;
            pop   = ~empty & out_ready[c];
            drop  = ~BLOCKING & in_valid[c] & full;
        end

        // in_ready is forced high during reset so the producer sees a clean start.
        assign in_ready[c]  = rst ? 1'b1 : (BLOCKING ? ~full : 1'b1);
        assign out_valid[c] = ~empty;
        assign out_data[c]  = mem[rd_ptr];
        assign level[c]     = lvl;
        assign drop_cnt[c]  = dcnt;
        assign drop_seen[c] = dseen;

        // Pointer, occupancy and drop bookkeeping; flush outranks push/pop.
        always_ff @(posedge clk) begin
            if (rst || flush[c]) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                lvl    <= '0;
                dcnt   <= '0;
                dseen  <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                lvl <= lvl + LW'(push) - LW'(pop);
                if (drop) begin
                    if (dcnt != 16'hFFFF) dcnt <= dcnt + 16'd1;
                    dseen <= 1'b1;
                end
            end
        end

        // Storage write; contents are not reset since pointers gate visibility.
        always_ff @(posedge clk) begin
            if (push && !flush[c] && !rst) mem[wr_ptr] <= in_data[c];
        end
    end

endmodule
